cache_mem_arbiter: RTL and testbench

Arbitrates the single shared main memory between the instruction-cache and data-cache fill engines. It sequences 8-word block fills, one word address per cycle, and single-word write-through stores. It routes returned read data back to the cache that owns the current transaction. It sits directly downstream of both caches' miss/fill logic and directly upstream of the 4-cycle pipelined memory model.

---
 rtl/cache_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shared main-memory arbiter for the I-cache and D-cache fill engines: 8-word burst fills and write-through stores.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed D-over-I priority for alternating tie-break.
module cache_mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  input  logic [15:0] dcache_addr,
  input  logic [15:0] dcache_wdata,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] fill_data,
  output logic [15:0] fill_addr,
  output logic        icache_fill_valid,
  output logic        dcache_fill_valid,
  output logic        icache_done,
  output logic        dcache_done,
  output logic        icache_grant,
  output logic        dcache_grant
);
  localparam int CW = $clog2(BLOCK_WORDS);
  localparam logic [CW:0] CNT_MAX  = (CW+1)'(BLOCK_WORDS);
  localparam logic [CW:0] CNT_LAST = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t      state, state_nxt;
  logic [11:0] base;
  logic [CW:0] issue_cnt, ret_cnt;
  logic        fill_st, issuing, returning, pick_d;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^icache_addr[3:0];

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D side completed the most recent transaction
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           last_grant <= 1'b0;
    else if (icache_done) last_grant <= 1'b0;
    else if (dcache_done) last_grant <= 1'b1;
  end

  assign pick_d = dcache_req & (~icache_req | ~last_grant);
`else
  assign pick_d = dcache_req;
`endif

  assign fill_st   = (state == I_FILL) || (state == D_FILL);
  assign issuing   = fill_st && (issue_cnt < CNT_MAX);
  assign returning = fill_st && mem_data_valid && (ret_cnt < CNT_MAX);

  assign icache_grant = (state == I_FILL);
  assign dcache_grant = (state == D_FILL) || (state == D_WRITE);
  assign fill_data    = (icache_fill_valid | dcache_fill_valid) ? mem_data_out : 16'h0;

  always_comb begin
    state_nxt         = state;
    mem_en            = 1'b0;
    mem_wr            = 1'b0;
    mem_addr          = 16'h0;
    mem_wdata         = 16'h0;
    fill_addr         = 16'h0;
    icache_fill_valid = 1'b0;
    dcache_fill_valid = 1'b0;
    icache_done       = 1'b0;
    dcache_done       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d)          state_nxt = dcache_wr ? D_WRITE : D_FILL;
        else if (icache_req) state_nxt = I_FILL;
      end
      I_FILL, D_FILL: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = {base, issue_cnt[CW-1:0], 1'b0};
        end
        if (returning) begin
          fill_addr = {base, ret_cnt[CW-1:0], 1'b0};
          if (state == I_FILL) icache_fill_valid = 1'b1;
          else                 dcache_fill_valid = 1'b1;
          if (ret_cnt == CNT_LAST) begin
            if (state == I_FILL) icache_done = 1'b1;
            else                 dcache_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      D_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dcache_addr;
        mem_wdata   = dcache_wdata;
        dcache_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= 12'h0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
        if (state_nxt == I_FILL)      base <= icache_addr[15:4];
        else if (state_nxt == D_FILL) base <= dcache_addr[15:4];
      end else begin
        if (issuing)   issue_cnt <= issue_cnt + 1'b1;
        if (returning) ret_cnt   <= ret_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: grant-vector table, directed corner sequences, and random
// request streams scored against a transaction-level model with a 4-cycle memory.
module tb_cache_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_req, dcache_req, dcache_wr;
  logic [15:0] icache_addr, dcache_addr, dcache_wdata;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data, fill_addr;
  logic        icache_fill_valid, dcache_fill_valid, icache_done, dcache_done;
  logic        icache_grant, dcache_grant;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .fill_addr(fill_addr),
    .icache_fill_valid(icache_fill_valid), .dcache_fill_valid(dcache_fill_valid),
    .icache_done(icache_done), .dcache_done(dcache_done),
    .icache_grant(icache_grant), .dcache_grant(dcache_grant)
  );

  // memory: read issued in cycle c returns in cycle c+4; contents are a fixed function of address
  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic [3:0]  pv = 4'b0;
  logic [15:0] pa [4];
  logic        stray = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_data_valid = pv[3] | stray;
  assign mem_data_out   = pv[3] ? memfn(pa[3]) : 16'hDEAD;

  logic [71:0] all_out;
  assign all_out = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_addr,
                    icache_fill_valid, dcache_fill_valid, icache_done, dcache_done,
                    icache_grant, dcache_grant};

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // transaction-level model state
  logic        i_pend = 1'b0, d_pend = 1'b0, d_wr_p = 1'b0, lastwin_d = 1'b0;
  logic [15:0] i_a = 16'h0, d_a = 16'h0, d_wd = 16'h0;
  int          exp_gap = 1;

  function automatic logic model_pick_d();
`ifdef ARB_ROUND_ROBIN_EN
    return d_pend && (!i_pend || !lastwin_d);
`else
    return d_pend;
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    icache_req = 1'b0; dcache_req = 1'b0; dcache_wr = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; lastwin_d = 1'b0;
    #1 chk("reset_outputs", all_out, 0);
    @(negedge clk) rst_n = 1'b1;
    // in-flight memory returns drain here and must be ignored
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", {icache_fill_valid, dcache_fill_valid, icache_done,
          dcache_done, icache_grant, dcache_grant, mem_en}, 0);
    end
    exp_gap = 1;
  endtask

  // Drive pending requests, wait for the grant, then score the whole transaction cycle by cycle.
  task automatic run_txn();
    logic        wd, seen;
    logic [15:0] base, ea;
    logic [33:0] ei, ef;
    wd = model_pick_d();
    icache_req = i_pend; icache_addr = i_a;
    dcache_req = d_pend; dcache_wr = d_wr_p; dcache_addr = d_a; dcache_wdata = d_wd;
    seen = 1'b0;
    for (int k = 1; k <= 4 && !seen; k++) begin
      @(negedge clk);
      if (icache_grant | dcache_grant) begin
        seen = 1'b1;
        chk("grant_latency", k, exp_gap);
      end
    end
    if (!seen) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    if (wd && d_wr_p) begin
      chk("write_cycle", {icache_grant, dcache_grant, mem_en, mem_wr, mem_addr, mem_wdata,
          icache_done, dcache_done}, {2'b01, 2'b11, d_a, d_wd, 2'b01});
      d_pend = 1'b0; dcache_req = 1'b0;
    end else begin
      base = (wd ? d_a : i_a) & 16'hFFF0;
      for (int j = 0; j < 12; j++) begin
        if (j > 0) @(negedge clk);
        chk("grant_hold", {icache_grant, dcache_grant}, wd ? 2'b01 : 2'b10);
        ei = '0;
        if (j < 8) ei = {2'b10, base + 16'(2*j), 16'h0};
        chk($sformatf("issue_w%0d", j), {mem_en, mem_wr, mem_addr, mem_wdata}, ei);
        ef = '0;
        if (j >= 4) begin
          ea = base + 16'(2*(j-4));
          ef = {~wd, wd, ea, memfn(ea)};
        end
        chk($sformatf("return_w%0d", j), {icache_fill_valid, dcache_fill_valid, fill_addr, fill_data}, ef);
        chk("done_pulse", {icache_done, dcache_done}, (j == 11) ? {~wd, wd} : 2'b00);
      end
      if (wd) begin d_pend = 1'b0; dcache_req = 1'b0; end
      else    begin i_pend = 1'b0; icache_req = 1'b0; end
    end
    lastwin_d = wd;
    exp_gap   = 2;
  endtask

  typedef struct {
    logic        ireq, dreq, dwr;
    logic [15:0] ia, da;
    logic [3:0]  exp_ctl;   // {icache_grant, dcache_grant, mem_en, mem_wr}
    logic [15:0] exp_addr;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int nret;
    logic ok;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'b1010, 16'h1230};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hABCD, 4'b0110, 16'hABC0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0040, 4'b0111, 16'h0040};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 4'b0110, 16'h2220};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h7777, 4'b0111, 16'h7777};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 4'b0000, 16'h0000};

    icache_req = 1'b0; dcache_req = 1'b0; dcache_wr = 1'b0;
    icache_addr = 16'h0; dcache_addr = 16'h0; dcache_wdata = 16'h0;
    #12 chk("reset_state", all_out, 0);
    @(negedge clk) rst_n = 1'b1;

    // one-cycle grant decode from IDLE, reset between entries
    for (int i = 0; i < 6; i++) begin
      icache_req = tbl[i].ireq; icache_addr = tbl[i].ia;
      dcache_req = tbl[i].dreq; dcache_wr = tbl[i].dwr;
      dcache_addr = tbl[i].da;  dcache_wdata = 16'h1357;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {icache_grant, dcache_grant, mem_en, mem_wr}, tbl[i].exp_ctl);
      chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].exp_ctl[0] ? 16'h1357 : 16'h0);
      do_reset();
    end

    // single I fill at 0x1234
    i_pend = 1'b1; i_a = 16'h1234;
    run_txn();
    // D write 0x0040 <- 0xBEEF
    d_pend = 1'b1; d_wr_p = 1'b0; d_wr_p = 1'b1; d_a = 16'h0040; d_wd = 16'hBEEF;
    run_txn();
    // simultaneous fills, then the loser back-to-back
    i_pend = 1'b1; i_a = 16'h2000; d_pend = 1'b1; d_wr_p = 1'b0; d_a = 16'h3000;
    run_txn();
    run_txn();
    // D fill while I held high: one IDLE cycle, then I, D never re-granted
    i_pend = 1'b1; i_a = 16'h5550; d_pend = 1'b1; d_wr_p = 1'b0; d_a = 16'h4440;
    run_txn();
    run_txn();

    // stray valid in IDLE
    @(negedge clk);
    @(negedge clk);
    stray = 1'b1;
    #1 chk("stray_ignored", {icache_fill_valid, dcache_fill_valid, icache_done, dcache_done, fill_data}, 0);
    @(negedge clk) stray = 1'b0;
    chk("stray_no_state_change", {icache_grant, dcache_grant, mem_en}, 0);
    exp_gap = 1;

    // reset after 3 words returned
    icache_req = 1'b1; icache_addr = 16'h6660;
    nret = 0;
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(negedge clk);
      if (icache_fill_valid) nret++;
      if (nret == 3) ok = 1'b1;
    end
    chk("three_returns_seen", ok, 1'b1);
    do_reset();

    // random streams
    for (int n = 0; n < 30; n++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1; i_a = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1; d_wr_p = 1'($urandom_range(0, 1));
        d_a = 16'($urandom); d_wd = 16'($urandom);
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1'b1; i_a = 16'($urandom);
      end
      run_txn();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
